// File: rtl/joy_shift_sequencer.sv
// Serial joystick reader: load-strobes a 24-bit shift-register chain, clocks it out
// on a slot grid derived from clk, and commits both players atomically per frame.
module joy_shift_sequencer #(
    parameter int CLK_DIV = 32,
    parameter bit FILTER  = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        JOY_DATA,
    output logic        JOY_CLK,
    output logic        JOY_LOAD,
    output logic [11:0] joystick1,
    output logic [11:0] joystick2,
    output logic        frame_valid,
    output logic        busy
);
    localparam int            CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_SHIFT, S_COMMIT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    k_q, k_d;
    logic [23:0]   sh_q, sh_d, prev_q, prev_d;
    logic [11:0]   j1_q, j1_d, j2_q, j2_d;
    logic          fv_q, fv_d;
    logic          slot_end;

    // lo = the eight k-ordered bits 8,6,5..0; hi = the four k-ordered bits 10,11,9,7
    function automatic logic [11:0] unpack_frame(input logic [7:0] lo, input logic [3:0] hi);
        return {hi[1], hi[0], hi[2], lo[0], hi[3], lo[1],
                lo[2], lo[3], lo[4], lo[5], lo[6], lo[7]};
    endfunction

    assign slot_end = (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = slot_end ? '0 : cnt_q + CW'(1);
        k_d     = k_q;
        sh_d    = sh_q;
        prev_d  = prev_q;
        j1_d    = j1_q;
        j2_d    = j2_q;
        fv_d    = 1'b0;
        case (state_q)
            S_IDLE:   if (enable && slot_end) state_d = S_LOAD;
            S_LOAD:   if (slot_end) state_d = S_SETTLE;
            S_SETTLE: if (slot_end) begin
                state_d = S_SHIFT;
                k_d     = '0;
            end
            S_SHIFT: begin
                if (cnt_q == HALF) sh_d[k_q] = JOY_DATA;
                if (slot_end) begin
                    if (k_q == 5'd23) state_d = S_COMMIT;
                    else              k_d     = k_q + 5'd1;
                end
            end
            S_COMMIT: begin
                // Counter holds here so the next LOAD starts on a clean slot boundary.
                cnt_d  = cnt_q;
                prev_d = sh_q;
                if (!FILTER || sh_q == prev_q) begin
                    j1_d = unpack_frame(sh_q[7:0],  sh_q[23:20]);
                    j2_d = unpack_frame(sh_q[15:8], sh_q[19:16]);
                    fv_d = 1'b1;
                end
                state_d = enable ? S_LOAD : S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
            sh_q    <= '1;
            prev_q  <= '1;
            j1_q    <= '1;
            j2_q    <= '1;
            fv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            sh_q    <= sh_d;
            prev_q  <= prev_d;
            j1_q    <= j1_d;
            j2_q    <= j2_d;
            fv_q    <= fv_d;
        end
    end

    assign JOY_LOAD    = (state_q != S_LOAD);
    assign JOY_CLK     = (state_q == S_SETTLE || state_q == S_SHIFT) && (cnt_q >= HALF);
    assign busy        = (state_q != S_IDLE);
    assign joystick1   = j1_q;
    assign joystick2   = j2_q;
    assign frame_valid = fv_q;
endmodule

// File: doc/joy_shift_sequencer.md
JOY_SHIFT_SEQUENCER -- requirements
Module: joy_shift_sequencer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 32: clk cycles per serial bit slot; even, >= 4.
REQ-002 SHALL have parameter FILTER, default 1: when 1, outputs update only after two consecutive identical frames; when 0, every frame commits.
REQ-003 SHALL have port clk, input, 1: the single clock for all logic.
REQ-004 SHALL have port reset_n, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port enable, input, 1: when 1, scanning runs free; when 0, the block finishes the current frame and then idles.
REQ-006 SHALL have port JOY_DATA, input, 1: serial data from the external shift-register chain.
REQ-007 SHALL have port JOY_CLK, output, 1: shift clock to the chain.
REQ-008 SHALL have port JOY_LOAD, output, 1: active-low parallel-load strobe to the chain.
REQ-009 SHALL have port joystick1, output, 12: player 1 controls, active-low.
REQ-010 SHALL have port joystick2, output, 12: player 2 controls, active-low.
REQ-011 SHALL have port frame_valid, output, 1: one-cycle pulse when joystick1/joystick2 update.
REQ-012 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-013 SHALL derive a slot counter 0..CLK_DIV-1 that wraps, and SHALL NOT derive clocks; all logic runs on clk.
REQ-014 SHALL implement states IDLE, LOAD, SETTLE, SHIFT, COMMIT.
REQ-015 IDLE: when enable=1, SHALL go to LOAD at the next slot boundary (counter wrap).
REQ-016 LOAD: JOY_LOAD=0 for exactly one slot; JOY_CLK=0; then SHALL go to SETTLE.
REQ-017 SETTLE: one slot with JOY_LOAD=1 and JOY_CLK pulsed (high in second half); data is discarded; then SHALL go to SHIFT.
REQ-018 SHIFT: 24 slots, bit index k=0..23; JOY_CLK=0 for counter < CLK_DIV/2, else 1.
REQ-019 In SHIFT, JOY_DATA SHALL be sampled in the clk cycle where counter == CLK_DIV/2 (the JOY_CLK rising edge), into a 24-bit frame shadow register at index k.
REQ-020 Frame map: k0-7 -> joy1[8,6,5,4,3,2,1,0]; k8-15 -> joy2[8,6,5,4,3,2,1,0]; k16-19 -> joy2[10,11,9,7]; k20-23 -> joy1[10,11,9,7].
REQ-021 After k=23, the block SHALL go to COMMIT for exactly one clk cycle.
REQ-022 COMMIT, FILTER=0: SHALL load joystick1/joystick2 from the shadow atomically and pulse frame_valid.
REQ-023 COMMIT, FILTER=1: SHALL commit and pulse only if the shadow equals the previous frame; in all cases the shadow SHALL be stored as the previous frame.
REQ-024 After COMMIT, the block SHALL go to LOAD if enable=1, else IDLE, aligned to the next slot boundary.
REQ-025 Outputs SHALL never show a partially shifted frame.
REQ-026 enable deasserted mid-frame SHALL NOT abort the frame.
REQ-027 Frame length SHALL be exactly 26*CLK_DIV cycles plus COMMIT plus realignment, and SHALL be deterministic.
REQ-028 In IDLE: JOY_LOAD=1 and JOY_CLK=0.

Reset
REQ-029 reset_n=0 at a clk edge SHALL force: state IDLE, counter 0, JOY_LOAD=1, JOY_CLK=0, joystick1=joystick2=12'hFFF, previous frame all ones, frame_valid=0, busy=0.
REQ-030 Reset during SHIFT SHALL discard the partial frame and leave outputs at 12'hFFF.

Verification
REQ-031 FILTER=0, CLK_DIV=4, chain model drives all 1s except k=3 = 0 -> one frame_valid; joystick1=12'hFEF (bit4 low); joystick2=12'hFFF.
REQ-032 FILTER=1, first frame all 0s -> no frame_valid; second identical frame -> frame_valid; joystick1=joystick2=12'h000.
REQ-033 FILTER=1, alternating frames k21=0 then k21=1 -> no frame_valid; outputs hold previous values.
REQ-034 enable dropped at k=10 -> frame completes and commits; busy falls after COMMIT; JOY_LOAD stays 1 thereafter.
REQ-035 reset_n low for 1 cycle at k=12 -> next cycle: JOY_CLK=0, JOY_LOAD=1, outputs 12'hFFF; rescan starts with a fresh LOAD slot.
REQ-036 Timing check with CLK_DIV=32 -> JOY_LOAD low exactly 32 cycles per frame; 25 JOY_CLK rising edges per frame; sample lands on each rising edge.
